// File: rtl/gf2m_reduce_seq.sv
// Multi-cycle reduction of a GF(2)[x] product modulo x^M + x^K3 + x^K2 + x^K1 + 1, folding FOLD bits per cycle.
// Optional squaring input path (port in_sqr) is enabled by defining GF_RED_SQR_EN.
module gf2m_reduce_seq #(
    parameter int M    = 163,
    parameter int IN_W = 325,
    parameter int K1   = 3,
    parameter int K2   = 6,
    parameter int K3   = 7,
    parameter int FOLD = 41
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
`ifdef GF_RED_SQR_EN
    input  logic            in_sqr,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M-1:0]    out_data,
    output logic            busy
);

    localparam int E     = IN_W - M;
    localparam int NCYC  = (E + FOLD - 1) / FOLD;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    if (!(IN_W > M && IN_W <= 2*M - 1)) begin : g_bad_in_w
        $error("gf2m_reduce_seq: IN_W must satisfy M < IN_W <= 2M-1");
    end
    if (!(K1 > 0 && K1 < K2 && K2 < K3 && K3 < M)) begin : g_bad_taps
        $error("gf2m_reduce_seq: taps must satisfy 0 < K1 < K2 < K3 < M");
    end
    if (!(FOLD >= 1 && FOLD <= M - K3)) begin : g_bad_fold
        $error("gf2m_reduce_seq: FOLD must satisfy 1 <= FOLD <= M-K3");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [M-1:0]      out_data_q, out_data_d;
    logic [IN_W-1:0]   load_val;
    logic [IN_W-1:0]   fold_sel;
    logic [IN_W-1:0]   fold_res [NCYC];

`ifdef GF_RED_SQR_EN
    if (IN_W != 2*M - 1) begin : g_bad_sqr_w
        $error("gf2m_reduce_seq: squaring path requires IN_W == 2M-1");
    end

    // Squaring in GF(2)[x] is a pure bit spread: cross terms cancel in pairs.
    logic [IN_W-1:0] spread;
    for (genvar gi = 0; gi < M; gi++) begin : g_spread_even
        assign spread[2*gi] = in_data[gi];
    end
    for (genvar gi = 0; gi < M - 1; gi++) begin : g_spread_odd
        assign spread[2*gi+1] = 1'b0;
    end
    assign load_val = in_sqr ? spread : in_data;
`else
    assign load_val = in_data;
`endif

    // One fold network per chunk; chunk gi is the one handled when cnt == gi.
    // Every target of a chunk lands strictly below its lowest bit, so a single pass is exact.
    for (genvar gi = 0; gi < NCYC; gi++) begin : g_chunk
        localparam int LO = M + FOLD * (NCYC - 1 - gi);
        localparam int HI = (LO + FOLD - 1 > IN_W - 1) ? (IN_W - 1) : (LO + FOLD - 1);
        localparam int W  = HI - LO + 1;
        localparam int SH = LO - M;
        localparam logic [IN_W-1:0] ONES_W = {{(IN_W-W){1'b0}}, {W{1'b1}}};

        logic [IN_W-1:0] chunk;
        logic [IN_W-1:0] cleared;

        assign chunk   = {{(IN_W-W){1'b0}}, acc_q[HI:LO]};
        assign cleared = acc_q & ~(ONES_W << LO);
        assign fold_res[gi] = cleared
                            ^ (chunk << SH)
                            ^ (chunk << (SH + K1))
                            ^ (chunk << (SH + K2))
                            ^ (chunk << (SH + K3));
    end

    assign fold_sel = fold_res[cnt_q];

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = load_val;
                    cnt_d   = '0;
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                acc_d = fold_sel;
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_LAST) begin
                    out_data_d = fold_sel[M-1:0];
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Self-checking bench for gf2m_reduce_seq: long-division reference model, scoreboard with
// latency/hold checks, directed vectors plus randomised inputs under random backpressure.
module tb_gf2m_reduce_seq;

    localparam int M    = 163;
    localparam int IN_W = 325;
    localparam int K1   = 3;
    localparam int K2   = 6;
    localparam int K3   = 7;
    localparam int FOLD = 41;
    localparam int NCYC = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [M-1:0]    out_data;
    logic            busy;
`ifdef GF_RED_SQR_EN
    logic            in_sqr = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bp_mode  = 0;
    int last_hs  = -100;

    typedef struct {
        logic [M-1:0] exp;
        int           acc_edge;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf2m_reduce_seq #(
        .M(M), .IN_W(IN_W), .K1(K1), .K2(K2), .K3(K3), .FOLD(FOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef GF_RED_SQR_EN
        .in_sqr   (in_sqr),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Schoolbook polynomial long division, top bit first.
    function automatic logic [M-1:0] gmod(input logic [IN_W-1:0] a);
        logic [IN_W-1:0] r;
        r = a;
        for (int i = IN_W - 1; i >= M; i--) begin
            if (r[i]) begin
                r[i]           = 1'b0;
                r[i-M]         = ~r[i-M];
                r[i-M+K1]      = ~r[i-M+K1];
                r[i-M+K2]      = ~r[i-M+K2];
                r[i-M+K3]      = ~r[i-M+K3];
            end
        end
        return r[M-1:0];
    endfunction

    // Carry-less product a*a of the low M bits.
    function automatic logic [IN_W-1:0] gsq(input logic [IN_W-1:0] a);
        logic [IN_W-1:0] p;
        p = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                if (a[i] && a[j]) p[i+j] = ~p[i+j];
        return p;
    endfunction

    function automatic logic [IN_W-1:0] xpow(input int n);
        logic [IN_W-1:0] r;
        r = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    task automatic send(input logic [IN_W-1:0] d, input bit sqr, output int acc_edge);
        int n;
        exp_t e;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
`ifdef GF_RED_SQR_EN
        in_sqr = sqr;
`endif
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
            in_valid = 1'b0;
            acc_edge = -1;
            return;
        end
        acc_edge   = cyc + 1;
        e.exp      = gmod(sqr ? gsq(d) : d);
        e.acc_edge = acc_edge;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef GF_RED_SQR_EN
        in_sqr = 1'b0;
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
        end
    endtask

    // Scoreboard: checks latency and value on each rising out_valid, stability while stalled.
    logic [M-1:0] held = '0;
    bit           ov_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            ov_prev = 1'b0;
        end else begin
            if (out_valid) begin
                if (!ov_prev) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_out: got out_valid=1 expected no pending result");
                    end else begin
                        chk("latency", IN_W'(cyc - q[0].acc_edge), IN_W'(NCYC));
                        chk("out_data", IN_W'(out_data), IN_W'(q[0].exp));
                    end
                    held = out_data;
                end else begin
                    chk("hold_data", IN_W'(out_data), IN_W'(held));
                end
                if (out_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    last_hs = cyc + 1;
                end
            end
            ov_prev = out_valid && !out_ready;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, n;
        logic [IN_W-1:0] lit;
        logic [IN_W-1:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", IN_W'(in_ready), IN_W'(1));
        chk("rst_out_valid", IN_W'(out_valid), IN_W'(0));
        chk("rst_busy", IN_W'(busy), IN_W'(0));
        chk("rst_out_data", IN_W'(out_data), IN_W'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pin the reference model with hand-derived reductions
        chk("model_x163", IN_W'(gmod(xpow(163))), IN_W'(8'hC9));
        lit = xpow(88) | xpow(87) | xpow(84) | xpow(81);
        chk("model_x244", IN_W'(gmod(xpow(244))), lit);
        lit = xpow(44) | xpow(43) | xpow(40) | xpow(37);
        chk("model_x200", IN_W'(gmod(xpow(200))), lit);
        chk("model_small", IN_W'(gmod(IN_W'(16'h1234))), IN_W'(16'h1234));

        // T1-T3 directed
        send(xpow(163), 1'b0, a); wait_idle();
        chk("t1_x163", IN_W'(out_data), IN_W'(8'hC9));
        send(xpow(244), 1'b0, a); wait_idle();
        chk("t2_x244", IN_W'(out_data), xpow(88) | xpow(87) | xpow(84) | xpow(81));
        send(xpow(200), 1'b0, a); wait_idle();
        chk("t2_x200", IN_W'(out_data), xpow(44) | xpow(43) | xpow(40) | xpow(37));
        send(IN_W'(16'h1234), 1'b0, a); wait_idle();
        chk("t3_small", IN_W'(out_data), IN_W'(16'h1234));
        send('0, 1'b0, a); wait_idle();
        chk("t3_zero", IN_W'(out_data), '0);

        // T4 backpressure
        bp_mode = 2;
        send(xpow(244), 1'b0, a);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_valid_rise", IN_W'(out_valid), IN_W'(1));
        in_data  = '1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_in_ready", IN_W'(in_ready), IN_W'(0));
            chk("t4_out_valid", IN_W'(out_valid), IN_W'(1));
            @(posedge clk); #1;
        end
        bp_mode = 0;
        send(xpow(200), 1'b0, b);
        chk("t4_next_accept", IN_W'(b), IN_W'(last_hs + 1));
        wait_idle();

        // T5 reset during the third fold
        send(xpow(300), 1'b0, a);
        @(posedge clk);
        @(posedge clk); #3;
        chk("t5_busy_pre", IN_W'(busy), IN_W'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", IN_W'(out_valid), IN_W'(0));
        chk("t5_in_ready", IN_W'(in_ready), IN_W'(1));
        chk("t5_busy", IN_W'(busy), IN_W'(0));
        @(negedge clk);
        q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(xpow(244), 1'b0, a); wait_idle();
        chk("t5_after", IN_W'(out_data), xpow(88) | xpow(87) | xpow(84) | xpow(81));

`ifdef GF_RED_SQR_EN
        send(xpow(100), 1'b1, a); wait_idle();
        chk("sqr_x100", IN_W'(out_data), xpow(44) | xpow(43) | xpow(40) | xpow(37));
`endif

        // T6 all-ones plus random inputs under random backpressure
        bp_mode = 1;
        send('1, 1'b0, a);
        for (int k = 0; k < 2000; k++) begin
            d = '0;
            for (int w = 0; w < IN_W; w += 32) d = (d << 32) | IN_W'($urandom());
            if (k % 7 == 0) d = d & (d >> 3) & (d >> 11);
            send(d, 1'b0, a);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        bp_mode = 0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
